// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter
// Shares one banked SRAM port between N_REQ load/store requesters.
// Round-robin arbitration grants at most one request per cycle. A granted
// byte address is decoded into {bank, word}, and the bank strobes are driven
// combinationally from the grant. Reads return on a shared response bus
// RD_LAT cycles later. Each requester may have only one read outstanding.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid/we   per-requester request valid and write flag
//   req_addr       per-requester byte address (slice i = requester i)
//   req_wdata      per-requester write data
//   req_wmask      per-requester byte mask (1 = keep the old byte)
//   req_ready      one-hot grant, combinational
//   rsp_valid      one-hot read-return pulse
//   rsp_rdata      read data of the returning requester
//   rsp_err        the returning read was out of range (rsp_rdata = 0)
//   mem_en         one-hot bank enable
//   mem_we         write strobe for the enabled bank
//   mem_addr       word address within the bank
//   mem_wdata      write data
//   mem_wmask      byte mask for the write
//   mem_rdata      per-bank read data, valid RD_LAT cycles after mem_en
//   busy           a request is waiting or a read is in flight
module sram_bank_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = DATA_W / 8,
  parameter int BANKS      = 8,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*BYTE_W-1:0]   req_wmask,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [BANKS-1:0]          mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [BYTE_W-1:0]         mem_wmask,
  input  logic [BANKS*DATA_W-1:0]   mem_rdata,
  output logic                      busy
);

  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ID_W   = $clog2(N_REQ);
  localparam int HI_LSB = 2 + MEM_ADDR_W + BANK_W;

  // Out of range: any bit above the bank field, or a bank index that does
  // not exist (only possible when BANKS is not a power of two or is 1).
  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    logic [BANK_W-1:0] b;
    b = a[2+MEM_ADDR_W +: BANK_W];
    return ((a >> HI_LSB) != '0) || (int'(b) >= BANKS);
  endfunction

  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  pending;

  logic              vld_p  [RD_LAT];
  logic [ID_W-1:0]   id_p   [RD_LAT];
  logic [BANK_W-1:0] bank_p [RD_LAT];
  logic              err_p  [RD_LAT];

  logic              ret_vld;
  logic [ID_W-1:0]   ret_id;
  logic [BANK_W-1:0] ret_bank;
  logic              ret_err;
  logic [N_REQ-1:0]  ret_hot;

  logic [N_REQ-1:0]  elig;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic [BANK_W-1:0] gnt_bank;
  logic              gnt_we;
  logic              gnt_oor;
  logic              mem_access;
  logic              rd_gnt;

  assign ret_vld  = vld_p[RD_LAT-1];
  assign ret_id   = id_p[RD_LAT-1];
  assign ret_bank = bank_p[RD_LAT-1];
  assign ret_err  = err_p[RD_LAT-1];
  assign ret_hot  = ret_vld ? (N_REQ'(1) << ret_id) : '0;

  // A read returning this cycle frees its requester for a new grant now.
  assign elig = rst_n ? (req_valid & ~(pending & ~ret_hot)) : '0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && elig[ID_W'((int'(rr_ptr) + k) % N_REQ)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign gnt_addr   = req_addr[gnt_id*ADDR_W +: ADDR_W];
  assign gnt_bank   = gnt_addr[2+MEM_ADDR_W +: BANK_W];
  assign gnt_we     = req_we[gnt_id];
  assign gnt_oor    = addr_oor(gnt_addr);
  assign mem_access = gnt_any && !gnt_oor;
  // Out-of-range reads still travel down the return pipe to report rsp_err.
  assign rd_gnt     = gnt_any && !gnt_we;

  assign req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
  assign mem_en    = mem_access ? (BANKS'(1) << gnt_bank) : '0;
  assign mem_we    = mem_access && gnt_we;
  assign mem_addr  = mem_access ? gnt_addr[2 +: MEM_ADDR_W] : '0;
  assign mem_wdata = mem_access ? req_wdata[gnt_id*DATA_W +: DATA_W] : '0;
  assign mem_wmask = mem_access ? req_wmask[gnt_id*BYTE_W +: BYTE_W] : '0;

  assign busy = rst_n && ((|req_valid) || (|pending));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      pending <= '0;
      for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      if (gnt_any) rr_ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
      // A re-grant in the return cycle must win over the clear.
      pending <= (pending & ~ret_hot) | (rd_gnt ? req_ready : '0);
      // p0: read captured at its grant edge
      vld_p[0] <= rd_gnt;
      // p1..pN: aligned with the SRAM read latency
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    // p0: read captured at its grant edge
    id_p[0]   <= gnt_id;
    bank_p[0] <= gnt_bank;
    err_p[0]  <= gnt_oor;
    // p1..pN: aligned with the SRAM read latency
    for (int k = 1; k < RD_LAT; k++) begin
      id_p[k]   <= id_p[k-1];
      bank_p[k] <= bank_p[k-1];
      err_p[k]  <= err_p[k-1];
    end
  end

  // Return stage: select the bank that was addressed RD_LAT cycles ago.
  assign rsp_valid = ret_hot;
  assign rsp_err   = ret_vld && ret_err;
  assign rsp_rdata = (ret_vld && !ret_err) ? mem_rdata[ret_bank*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
module tb_sram_bank_arbiter;
  localparam int N_REQ      = 4;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 4;
  localparam int BANKS      = 8;
  localparam int MEM_ADDR_W = 10;
  localparam int RD_LAT     = 1;
  localparam int BANK_W     = 3;
  localparam int WORDS      = 1 << MEM_ADDR_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*BYTE_W-1:0] req_wmask;
  logic [DATA_W-1:0]       rsp_rdata, mem_wdata;
  logic                    rsp_err, mem_we, busy;
  logic [BANKS-1:0]        mem_en;
  logic [MEM_ADDR_W-1:0]   mem_addr;
  logic [BYTE_W-1:0]       mem_wmask;
  logic [BANKS*DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  sram_bank_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
    .BANKS(BANKS), .MEM_ADDR_W(MEM_ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [DATA_W-1:0] init_val(int idx);
    return 32'hC3A5_0F00 ^ (32'(idx) * 32'h9E37_79B1);
  endfunction

  // SRAM bank array attached to the DUT memory port.
  logic [DATA_W-1:0] sram [BANKS][WORDS];
  logic [DATA_W-1:0] dq   [BANKS][RD_LAT];
  bit                sram_init;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int b = 0; b < BANKS; b++)
        for (int w = 0; w < WORDS; w++) sram[b][w] <= init_val(b * WORDS + w);
      sram_init <= 1'b1;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        for (int k = 1; k < RD_LAT; k++) dq[b][k] <= dq[b][k-1];
        if (mem_en[b]) begin
          if (mem_we) begin
            for (int j = 0; j < BYTE_W; j++)
              if (!mem_wmask[j]) sram[b][mem_addr][8*j +: 8] <= mem_wdata[8*j +: 8];
          end else begin
            dq[b][0] <= sram[b][mem_addr];
          end
        end
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < BANKS; b++) mem_rdata[b*DATA_W +: DATA_W] = dq[b][RD_LAT-1];
  end

  // Reference model: flat word memory, round-robin pointer, per-requester
  // pending flag and a queue of expected responses with their due cycle.
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic [DATA_W-1:0] ref_mem [BANKS*WORDS];
  bit                pend [N_REQ];
  rsp_t              rq [$];
  int                rr;
  int                cyc;
  int                checks;
  int                errors;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    int                ret;
    int                g;
    int                idx;
    bit                inr;
    bit                any_pend;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rdat;
    logic [DATA_W-1:0] wd;
    logic [BYTE_W-1:0] wm;
    logic              rerr;
    logic [N_REQ-1:0]  er;
    logic [N_REQ-1:0]  ev;
    logic [BANKS-1:0]  een;
    logic              ewe;
    rsp_t              e;
    cyc++;
    if (!rst_n) begin
      chk("rst req_ready", 64'(req_ready), 64'h0);
      chk("rst mem_en", 64'(mem_en), 64'h0);
      chk("rst mem_we", 64'(mem_we), 64'h0);
      chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst rsp_err", 64'(rsp_err), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
      rr = 0;
      for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
      rq.delete();
      return;
    end
    ret = -1; rdat = '0; rerr = 1'b0; ev = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ret  = rq[0].id;
      rdat = rq[0].data;
      rerr = rq[0].err;
      ev[ret] = 1'b1;
      void'(rq.pop_front());
    end
    any_pend = 1'b0;
    for (int i = 0; i < N_REQ; i++) any_pend |= pend[i];
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (rr + k) % N_REQ;
      if (g < 0 && req_valid[i] && (!pend[i] || ret == i)) g = i;
    end
    er = '0; een = '0; ewe = 1'b0; inr = 1'b0; idx = 0; a = '0; wd = '0; wm = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      a   = req_addr[g*ADDR_W +: ADDR_W];
      wd  = req_wdata[g*DATA_W +: DATA_W];
      wm  = req_wmask[g*BYTE_W +: BYTE_W];
      inr = (a >> (2 + MEM_ADDR_W + BANK_W)) == 0;
      idx = int'(a[2 +: MEM_ADDR_W + BANK_W]);
      if (inr) begin
        een[idx / WORDS] = 1'b1;
        ewe = req_we[g];
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("mem_en", 64'(mem_en), 64'(een));
    chk("mem_we", 64'(mem_we), 64'(ewe));
    if (een != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(idx % WORDS));
      if (ewe) begin
        chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("mem_wmask", 64'(mem_wmask), 64'(wm));
      end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_err", 64'(rsp_err), 64'(rerr));
    if (ret >= 0) chk("rsp_rdata", 64'(rsp_rdata), 64'(rdat));
    chk("busy", 64'(busy), 64'((|req_valid) || any_pend));
    if (ret >= 0) pend[ret] = 1'b0;
    if (g >= 0) begin
      rr = (g + 1) % N_REQ;
      if (!req_we[g]) begin
        pend[g] = 1'b1;
        e.due  = cyc + RD_LAT;
        e.id   = g;
        e.data = inr ? ref_mem[idx] : '0;
        e.err  = !inr;
        rq.push_back(e);
      end else if (inr) begin
        for (int j = 0; j < BYTE_W; j++)
          if (!wm[j]) ref_mem[idx][8*j +: 8] = wd[8*j +: 8];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic set_req(int i, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                         logic [BYTE_W-1:0] m);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_wmask[i*BYTE_W +: BYTE_W] = m;
  endtask

  task automatic wr_lit(string nm, int i, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                        logic [BYTE_W-1:0] m, logic [BANKS-1:0] een, int eword);
    clear_reqs();
    set_req(i, 1'b1, a, d, m);
    #1;
    chk({nm, " ready"}, 64'(req_ready), 64'(1 << i));
    chk({nm, " mem_en"}, 64'(mem_en), 64'(een));
    chk({nm, " mem_we"}, 64'(mem_we), 64'h1);
    chk({nm, " mem_addr"}, 64'(mem_addr), 64'(eword));
    step();
    clear_reqs();
  endtask

  task automatic rd_lit(string nm, int i, logic [ADDR_W-1:0] a, logic [BANKS-1:0] een,
                        logic [DATA_W-1:0] ed, logic ee);
    clear_reqs();
    set_req(i, 1'b0, a, '0, '0);
    #1;
    chk({nm, " ready"}, 64'(req_ready), 64'(1 << i));
    chk({nm, " mem_en"}, 64'(mem_en), 64'(een));
    step();
    clear_reqs();
    for (int k = 1; k < RD_LAT; k++) step();
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(1 << i));
    chk({nm, " rsp_rdata"}, 64'(rsp_rdata), 64'(ed));
    chk({nm, " rsp_err"}, 64'(rsp_err), 64'(ee));
    step();
  endtask

  logic [N_REQ-1:0] rr_vld [5];
  logic [N_REQ-1:0] rr_exp [5];

  initial begin
    for (int n = 0; n < BANKS * WORDS; n++) ref_mem[n] = init_val(n);
    rr = 0; cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rr_vld = '{4'b1111, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset mem_en", 64'(mem_en), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1;

    // Single write/read and byte masking
    wr_lit("wr deadbeef", 0, 16'h0000, 32'hDEAD_BEEF, 4'b0000, 8'h01, 0);
    rd_lit("rd deadbeef", 0, 16'h0000, 8'h01, 32'hDEAD_BEEF, 1'b0);
    wr_lit("wr aa", 0, 16'h0000, 32'h0000_00AA, 4'b1110, 8'h01, 0);
    rd_lit("rd deadbeaa", 0, 16'h0000, 8'h01, 32'hDEAD_BEAA, 1'b0);
    wr_lit("wr beef", 0, 16'h0000, 32'hBEEF_0000, 4'b0011, 8'h01, 0);
    rd_lit("rd beefbeaa", 0, 16'h0000, 8'h01, 32'hBEEF_BEAA, 1'b0);

    // Bank decode
    wr_lit("wr bank1", 0, 16'h1004, 32'h1111_1111, 4'b0000, 8'h02, 1);
    wr_lit("wr bank0", 0, 16'h0004, 32'h2222_2222, 4'b0000, 8'h01, 1);
    rd_lit("rd bank1", 0, 16'h1004, 8'h02, 32'h1111_1111, 1'b0);
    rd_lit("rd bank0", 0, 16'h0004, 8'h01, 32'h2222_2222, 1'b0);

    // Out of range read
    rd_lit("rd oor", 0, 16'h8000, 8'h00, 32'h0, 1'b1);

    // Reset one cycle after a read grant, then round-robin from requester 0
    clear_reqs();
    set_req(0, 1'b0, 16'h1008, '0, '0);
    #1;
    chk("pre-reset ready", 64'(req_ready), 64'h1);
    step();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 16'(i << 12), '0, '0);
    rst_n = 1'b0;
    #1;
    chk("async rsp_valid", 64'(rsp_valid), 64'h0);
    chk("async req_ready", 64'(req_ready), 64'h0);
    chk("async mem_en", 64'(mem_en), 64'h0);
    chk("async mem_we", 64'(mem_we), 64'h0);
    chk("async busy", 64'(busy), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = rr_vld[c];
      #1;
      if (c == 0) chk("post-reset rsp_valid", 64'(rsp_valid), 64'h0);
      chk($sformatf("rr grant %0d", c), 64'(req_ready), 64'(rr_exp[c]));
      step();
    end
    clear_reqs();
    step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n = (n % 700 != 350);
      for (int i = 0; i < N_REQ; i++) begin
        logic [ADDR_W-1:0] a;
        a = '0;
        a[14:12] = 3'($urandom_range(0, 7));
        a[3:2]   = 2'($urandom_range(0, 3));
        a[1:0]   = 2'($urandom_range(0, 3));
        a[15]    = ($urandom_range(0, 15) == 0);
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_we[i]    = ($urandom_range(0, 2) == 0);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = $urandom;
        req_wmask[i*BYTE_W +: BYTE_W] = 4'($urandom_range(0, 15));
      end
      step();
    end
    rst_n = 1'b1;
    clear_reqs();
    for (int k = 0; k < RD_LAT + 1; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
